// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional stall timeout in uart_tx_arbiter is enabled with UART_ARB_TIMEOUT_EN.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int UART_BYTE_W = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  // Scan from the farthest offset down so the nearest set request is written last.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        gnt_id  = IDW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte interface between packet requesters.
// Define UART_ARB_TIMEOUT_EN to add the stall timeout (cfg_timeout / timeout ports).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TO_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         cfg_en,
`ifdef UART_ARB_TIMEOUT_EN
  input  logic [TO_W-1:0]              cfg_timeout,
`endif
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_last,
  input  logic [NREQ*UART_BYTE_W-1:0]  req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         tx_valid,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_ready,
  output logic                         busy,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                         timeout,
`endif
  output logic [$clog2(NREQ)-1:0]      grant_id
);

  localparam int IDW = $clog2(NREQ);

  // Handshake: a byte moves on a cycle where valid and ready are both high; the
  // requester holds valid/data/last stable until it sees ready, and may idle between bytes.
  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           g_valid;
  logic           g_last;
  logic           hs;
`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_W-1:0] stall_cnt;
`endif

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (int'(id) == NREQ - 1) return '0;
    return id + IDW'(1);
  endfunction

  uart_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt_id  (pick_id),
    .gnt_any (pick_any)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign hs      = (state == GRANT) && g_valid && tx_ready;

  // Pass-through in GRANT keeps the datapath bufferless; IDLE presents nothing.
  always_comb begin
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    if (state == GRANT) begin
      tx_valid            = g_valid;
      tx_data             = req_data[int'(grant_id)*UART_BYTE_W +: UART_BYTE_W];
      req_ready[grant_id] = tx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= IDLE;
      busy      <= 1'b0;
      grant_id  <= '0;
      ptr       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout   <= 1'b0;
      stall_cnt <= '0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg_en && pick_any) begin
            state    <= GRANT;
            busy     <= 1'b1;
            grant_id <= pick_id;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (hs) begin
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (g_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              ptr   <= next_id(grant_id);
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          // A byte handing over in the same cycle wins over the revoke.
          else if (cfg_timeout != '0 && stall_cnt >= cfg_timeout) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ptr       <= next_id(grant_id);
            timeout   <= 1'b1;
            stall_cnt <= '0;
          end else if (!g_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + TO_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps plus randomized packet traffic
// checked cycle by cycle against a queue-based ownership model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ      = 4;
  localparam int TO_W      = 16;
  localparam int IDW       = $clog2(NREQ);
  localparam int DEPTH     = 512;
  localparam int STALL_MAX = (1 << TO_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst_b;
  logic                cfg_en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_last;
  logic [NREQ*8-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                busy;
  logic [IDW-1:0]      grant_id;
`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_W-1:0]     cfg_timeout;
  logic                timeout;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(
    .NREQ (NREQ),
    .TO_W (TO_W)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .cfg_en      (cfg_en),
`ifdef UART_ARB_TIMEOUT_EN
    .cfg_timeout (cfg_timeout),
`endif
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
`ifdef UART_ARB_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .grant_id    (grant_id)
  );

  // ---------------- sources, model, scoreboard ----------------
  logic [7:0]      src_data [NREQ][DEPTH];
  logic            src_last [NREQ][DEPTH];
  int              src_head [NREQ];
  int              src_tail [NREQ];
  logic [NREQ-1:0] src_hold;
  logic [NREQ-1:0] last_hs;
  int              gap_pct, rdy_pct;
  bit              rdy_auto, en_auto;

  int              m_owner, m_gid, m_ptr, m_stall;
  bit              m_to;
  logic [7:0]      exp_q[$];
  int              hs_who[$];
  int              hs_cyc[$];
  int              hs_dat[$];
  int              to_seen[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_byte(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_tail[r]] = d;
    src_last[r][src_tail[r]] = l;
    src_tail[r]++;
  endtask

  task automatic rand_pkt(input int r);
    int len;
    len = $urandom_range(1, 5);
    for (int i = 0; i < len; i++) put_byte(r, 8'($urandom), i == len - 1);
  endtask

  task automatic clear_log();
    hs_who.delete(); hs_cyc.delete(); hs_dat.delete(); to_seen.delete();
  endtask

  // Driver: a presented byte stays put until its handshake, then the next one may follow.
  task automatic drive_src(input logic [NREQ-1:0] hs);
    for (int r = 0; r < NREQ; r++) begin
      if (hs[r]) src_head[r]++;
      if (req_valid[r] && !hs[r]) continue;
      if (src_head[r] < src_tail[r] && !src_hold[r] && $urandom_range(0, 99) >= gap_pct) begin
        req_valid[r]       = 1'b1;
        req_data[r*8 +: 8] = src_data[r][src_head[r]];
        req_last[r]        = src_last[r][src_head[r]];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[r*8 +: 8] = 8'h00;
        req_last[r]        = 1'b0;
      end
    end
    if (rdy_auto) tx_ready = ($urandom_range(0, 99) < rdy_pct);
    if (en_auto) cfg_en = ($urandom_range(0, 99) < 85);
  endtask

  // Model: one owner at a time; a free arbiter hands the next grant to the first
  // valid requester at or after the pointer, and the grant takes effect next cycle.
  task automatic check_cycle(output logic [NREQ-1:0] obs_hs);
    logic [NREQ-1:0] e_rdy;
    logic            e_txv;
    logic [7:0]      e_txd;
    bit              m_hs;
    e_rdy = '0; e_txv = 1'b0; e_txd = 8'h00; m_hs = 1'b0;
    if (m_owner >= 0) begin
      e_txv          = req_valid[m_owner];
      e_txd          = req_data[m_owner*8 +: 8];
      e_rdy[m_owner] = tx_ready;
      m_hs           = req_valid[m_owner] && tx_ready;
    end
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("grant_id", 32'(grant_id), m_gid);
    chk("tx_valid", 32'(tx_valid), 32'(e_txv));
    chk("tx_data", 32'(tx_data), 32'(e_txd));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(m_to));
    if (timeout === 1'b1) to_seen.push_back(cyc);
`endif
    m_to   = 1'b0;
    obs_hs = req_valid & req_ready;
    if (m_hs) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      hs_who.push_back(m_owner);
      hs_cyc.push_back(cyc);
      hs_dat.push_back(int'(tx_data));
    end
    if (m_owner >= 0) begin
      if (m_hs) begin
        m_stall = 0;
        if (req_last[m_owner]) begin
          chk("pkt_end", exp_q.size(), 0);
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (cfg_timeout != 0 && m_stall >= int'(cfg_timeout)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_to    = 1'b1;
        m_stall = 0;
        exp_q.delete();
      end else if (!req_valid[m_owner] && m_stall < STALL_MAX) begin
        m_stall++;
      end
`endif
    end else if (cfg_en && req_valid != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req_valid[r]) m_owner = r;
      end
      m_gid   = m_owner;
      m_stall = 0;
      for (int j = src_head[m_owner]; j < src_tail[m_owner]; j++) begin
        exp_q.push_back(src_data[m_owner][j]);
        if (src_last[m_owner][j]) break;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_src(last_hs);
      @(negedge clk);
      check_cycle(last_hs);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; last_hs = '0; src_hold = '0;
    for (int r = 0; r < NREQ; r++) begin
      src_head[r] = 0;
      src_tail[r] = 0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("rst_timeout", 32'(timeout), 0);
`endif
    m_owner = -1; m_gid = 0; m_ptr = 0; m_stall = 0; m_to = 1'b0;
    exp_q.delete();
    clear_log();
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  task automatic chk_hs(input string tag, input int idx, input int who, input int cyc_exp, input int dat);
    chk({tag, "_present"}, 32'(hs_who.size() > idx), 1);
    if (hs_who.size() > idx) begin
      chk({tag, "_who"}, hs_who[idx], who);
      chk({tag, "_cyc"}, hs_cyc[idx], cyc_exp);
      if (dat >= 0) chk({tag, "_dat"}, hs_dat[idx], dat);
    end
  endtask

  function automatic bit drained();
    bit d;
    d = (m_owner < 0) && (exp_q.size() == 0);
    for (int r = 0; r < NREQ; r++) if (src_head[r] != src_tail[r]) d = 1'b0;
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    int c0;
    bit done;
    rst_b = 1'b0; cfg_en = 1'b1; tx_ready = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    gap_pct = 0; rdy_pct = 100; rdy_auto = 1'b0; en_auto = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cfg_timeout = '0;
`endif

    // Single requester 3-byte packet, then pointer=1 shown by a 0/1 tie.
    do_reset();
    put_byte(0, 8'h11, 1'b0); put_byte(0, 8'h22, 1'b0); put_byte(0, 8'h33, 1'b1);
    c0 = cyc;
    run(6);
    chk_hs("t1_b0", 0, 0, c0 + 1, 8'h11);
    chk_hs("t1_b1", 1, 0, c0 + 2, 8'h22);
    chk_hs("t1_b2", 2, 0, c0 + 3, 8'h33);
    put_byte(0, 8'h55, 1'b1); put_byte(1, 8'h66, 1'b1);
    c0 = cyc;
    run(6);
    chk_hs("t1_ptr_first", 3, 1, c0 + 1, 8'h66);
    chk_hs("t1_ptr_second", 4, 0, c0 + 3, 8'h55);

    // Simultaneous requests from reset, then pointer wrap past req3.
    do_reset();
    put_byte(0, 8'hA0, 1'b1); put_byte(2, 8'hA2, 1'b1);
    c0 = cyc;
    run(6);
    chk_hs("t2_r0", 0, 0, c0 + 1, 8'hA0);
    chk_hs("t2_r2", 1, 2, c0 + 3, 8'hA2);
    put_byte(0, 8'hB0, 1'b1); put_byte(2, 8'hB2, 1'b1);
    c0 = cyc;
    run(6);
    chk_hs("t2_wrap_r0", 2, 0, c0 + 1, 8'hB0);
    chk_hs("t2_wrap_r2", 3, 2, c0 + 3, 8'hB2);
    put_byte(0, 8'hC0, 1'b1); put_byte(3, 8'hC3, 1'b1);
    c0 = cyc;
    run(6);
    chk_hs("t2_r3_first", 4, 3, c0 + 1, 8'hC3);
    chk_hs("t2_r0_after", 5, 0, c0 + 3, 8'hC0);

    // Non-interleave: req0 arrives while req1 is mid-packet.
    do_reset();
    for (int i = 0; i < 4; i++) put_byte(1, 8'(8'hD1 + i), i == 3);
    put_byte(0, 8'hD0, 1'b1);
    src_hold[0] = 1'b1;
    c0 = cyc;
    run(3);
    src_hold[0] = 1'b0;
    run(8);
    for (int i = 0; i < 4; i++) chk_hs("t3_r1", i, 1, c0 + 1 + i, 8'hD1 + i);
    chk_hs("t3_r0", 4, 0, c0 + 6, 8'hD0);

    // Backpressure pattern 1,0,0,1 on tx_ready.
    do_reset();
    put_byte(2, 8'hE1, 1'b0); put_byte(2, 8'hE2, 1'b0); put_byte(2, 8'hE3, 1'b1);
    c0 = cyc;
    tx_ready = 1'b1; run(2);
    tx_ready = 1'b0; run(2);
    tx_ready = 1'b1; run(3);
    chk_hs("t4_b0", 0, 2, c0 + 1, 8'hE1);
    chk_hs("t4_b1", 1, 2, c0 + 4, 8'hE2);
    chk_hs("t4_b2", 2, 2, c0 + 5, 8'hE3);

    // Enable gating, and cfg_en dropped mid-packet.
    do_reset();
    cfg_en = 1'b0;
    put_byte(3, 8'hF1, 1'b0); put_byte(3, 8'hF2, 1'b0); put_byte(3, 8'hF3, 1'b1);
    run(10);
    chk("t5_no_grant", hs_who.size(), 0);
    cfg_en = 1'b1;
    c0 = cyc;
    run(2);
    cfg_en = 1'b0;
    run(6);
    chk_hs("t5_b0", 0, 3, c0 + 1, 8'hF1);
    chk_hs("t5_b1", 1, 3, c0 + 2, 8'hF2);
    chk_hs("t5_b2", 2, 3, c0 + 3, 8'hF3);
    cfg_en = 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    // Stall timeout: req0 stalls mid-packet, req1 waits.
    do_reset();
    cfg_timeout = TO_W'(5);
    put_byte(0, 8'h77, 1'b0); put_byte(1, 8'h88, 1'b1);
    c0 = cyc;
    run(12);
    chk_hs("t6_r0", 0, 0, c0 + 1, 8'h77);
    chk("t6_pulses", to_seen.size(), 1);
    if (to_seen.size() != 0) chk("t6_to_cyc", to_seen[0], c0 + 8);
    chk_hs("t6_r1", 1, 1, c0 + 9, 8'h88);
    cfg_timeout = '0;
`endif

    // Reset mid-packet discards the grant.
    do_reset();
    for (int r = 0; r < NREQ; r++) rand_pkt(r);
    run(3);
    do_reset();
    run(3);

    // Randomized traffic with gaps, backpressure and enable toggling.
    do_reset();
    for (int r = 0; r < NREQ; r++) for (int p = 0; p < 25; p++) rand_pkt(r);
    gap_pct = 30; rdy_pct = 70; rdy_auto = 1'b1; en_auto = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      run(1);
      done = drained();
    end
    chk("rand_drained", 32'(done), 1);
    en_auto = 1'b0; rdy_auto = 1'b0; cfg_en = 1'b1; gap_pct = 0;
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
